rom_sequenced_datapath: RTL and testbench

- Self-sequencing successor to the hand-driven ROM → control unit → register-file/ALU chain.
- A program counter fetches instructions from an external combinational ROM, decodes them, and executes them on an internal parametrised register file and ALU.
- Adds immediate load, conditional branch, halt, a start/done handshake and illegal-opcode flagging.
- Used as the programmable datapath core fed by the existing rom block.

---
 rtl/rom_sequenced_datapath.sv | 194 +++++++++++++++++++
 tb/tb_rom_sequenced_datapath.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_sequenced_datapath.sv
// rom_sequenced_datapath
//   Self-sequencing programmable datapath. A program counter walks an
//   external combinational ROM; each instruction is fetched into an
//   instruction register, then decoded and executed against an internal
//   register file and ALU. Every instruction takes two cycles (FETCH, EXEC).
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   start     begin execution at pc 0 (only looked at in IDLE)
//   rom_addr  ROM address, always equal to pc
//   rom_data  ROM word for rom_addr (combinational)
//   busy      high while the program is running (FETCH/EXEC)
//   done      one-cycle pulse when execution ends
//   result    last value written to any register
//   illegal   sticky flag: undefined opcode or out-of-range branch seen
//   dbg_addr  debug register read address
//   dbg_data  combinational read of R[dbg_addr]
//
// Instruction word, MSB first: op[4] | wa | ra1 | ra2 | imm
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | pc held at 0, waiting for start
// FETCH | rom_data at pc is latched into the instruction register
// EXEC  | register write / result update, choose next pc or finish
// DONE  | one-cycle done pulse, back to IDLE
module rom_sequenced_datapath #(
  parameter  int DATA_W     = 8,
  parameter  int REG_ADDR_W = 4,
  parameter  int IMM_W      = 8,
  parameter  int PC_W       = 8,
  parameter  int PROG_LEN   = 256,
  localparam int INSTR_W    = 4 + 3*REG_ADDR_W + IMM_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [PC_W-1:0]       rom_addr,
  input  logic [INSTR_W-1:0]    rom_data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_W-1:0]     result,
  output logic                  illegal,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0]     dbg_data
);

  localparam int NREGS  = 2**REG_ADDR_W;
  localparam int IMM_DW = (IMM_W > DATA_W) ? IMM_W : DATA_W;
  localparam int IMM_PW = (IMM_W > PC_W) ? IMM_W : PC_W;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [DATA_W-1:0]   regs_q [NREGS];
  logic [DATA_W-1:0]   regs_d [NREGS];
  logic [DATA_W-1:0]   result_q, result_d;
  logic                illegal_q, illegal_d;

  // Decoded fields of the latched instruction
  logic [3:0]              op;
  logic [REG_ADDR_W-1:0]   wa, ra1, ra2;
  logic signed [IMM_W-1:0] imm_s;
  logic signed [IMM_DW-1:0] imm_sx;
  logic [IMM_PW-1:0]       imm_zx;
  logic [DATA_W-1:0]       imm_data;
  logic [PC_W-1:0]         br_tgt;
  logic                    br_oob;
  logic                    last_pc;
  logic [DATA_W-1:0]       opa, opb;

  assign op    = ir_q[INSTR_W-1 -: 4];
  assign wa    = ir_q[INSTR_W-5 -: REG_ADDR_W];
  assign ra1   = ir_q[INSTR_W-5-REG_ADDR_W -: REG_ADDR_W];
  assign ra2   = ir_q[IMM_W+REG_ADDR_W-1 -: REG_ADDR_W];
  assign imm_s = ir_q[IMM_W-1:0];

  // Widen first, then take the low bits: this covers both sign extension
  // (IMM_W < DATA_W) and truncation (IMM_W > DATA_W) with one expression.
  assign imm_sx   = IMM_DW'(imm_s);
  assign imm_data = imm_sx[DATA_W-1:0];
  assign imm_zx   = IMM_PW'(ir_q[IMM_W-1:0]);
  assign br_tgt   = imm_zx[PC_W-1:0];
  assign br_oob   = (32'(br_tgt) >= PROG_LEN);
  assign last_pc  = (pc_q == PC_W'(PROG_LEN-1));

  assign opa = regs_q[ra1];
  assign opb = regs_q[ra2];

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              taken;
  logic              stop;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    regs_d    = regs_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    wr_en     = 1'b0;
    wr_data   = '0;
    taken     = 1'b0;
    stop      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        pc_d = '0;
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        ir_d    = rom_data;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        unique case (op)
          4'h0: begin end
          4'h1: begin wr_en = 1'b1; wr_data = opa + opb; end
          4'h2: begin wr_en = 1'b1; wr_data = opa - opb; end
          4'h3: begin wr_en = 1'b1; wr_data = opa & opb; end
          4'h4: begin wr_en = 1'b1; wr_data = opa | opb; end
          4'h5: begin wr_en = 1'b1; wr_data = opa + imm_data; end
          4'h6: begin wr_en = 1'b1; wr_data = imm_data; end
          4'h7: begin
            if (opa == '0) begin
              // A branch outside the program is treated as a fault that
              // ends the run rather than fetching undefined ROM.
              if (br_oob) begin
                illegal_d = 1'b1;
                stop      = 1'b1;
              end else begin
                taken = 1'b1;
              end
            end
          end
          4'hF: stop = 1'b1;
          default: illegal_d = 1'b1;
        endcase

        if (wr_en) begin
          regs_d[wa] = wr_data;
          result_d   = wr_data;
        end

        if (stop) begin
          state_d = S_DONE;
        end else if (taken) begin
          pc_d    = br_tgt;
          state_d = S_FETCH;
        end else if (last_pc) begin
          state_d = S_DONE;
        end else begin
          pc_d    = pc_q + PC_W'(1);
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        pc_d    = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
      regs_q    <= regs_d;
    end
  end

  assign rom_addr = pc_q;
  assign busy     = (state_q == S_FETCH) || (state_q == S_EXEC);
  assign done     = (state_q == S_DONE);
  assign result   = result_q;
  assign illegal  = illegal_q;
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: tb/tb_rom_sequenced_datapath.sv
// Testbench for rom_sequenced_datapath: three instances with PROG_LEN of
// 256, 2 and 4 share clock and reset, each with its own ROM image.
module tb_rom_sequenced_datapath;

  logic             clk;
  logic             reset;
  logic [2:0]       start_v;
  logic [2:0][7:0]  rom_addr_v;
  logic [2:0][23:0] rom_data_v;
  logic [2:0]       busy_v;
  logic [2:0]       done_v;
  logic [2:0][7:0]  result_v;
  logic [2:0]       illegal_v;
  logic [2:0][3:0]  dbg_addr_v;
  logic [2:0][7:0]  dbg_data_v;

  logic [23:0] rom_mem [3][256];
  int          plen [3];

  int n_checks;
  int n_errors;

  // Reference model state (architectural view only)
  logic [7:0] m_regs [3][16];
  logic [7:0] m_result [3];
  logic       m_illegal [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rom_data_v[0] = rom_mem[0][rom_addr_v[0]];
  assign rom_data_v[1] = rom_mem[1][rom_addr_v[1]];
  assign rom_data_v[2] = rom_mem[2][rom_addr_v[2]];

  rom_sequenced_datapath #(.PROG_LEN(256)) u_dut0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .rom_addr(rom_addr_v[0]),
    .rom_data(rom_data_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .result(result_v[0]), .illegal(illegal_v[0]), .dbg_addr(dbg_addr_v[0]),
    .dbg_data(dbg_data_v[0]));

  rom_sequenced_datapath #(.PROG_LEN(2)) u_dut1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .rom_addr(rom_addr_v[1]),
    .rom_data(rom_data_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .result(result_v[1]), .illegal(illegal_v[1]), .dbg_addr(dbg_addr_v[1]),
    .dbg_data(dbg_data_v[1]));

  rom_sequenced_datapath #(.PROG_LEN(4)) u_dut2 (
    .clk(clk), .reset(reset), .start(start_v[2]), .rom_addr(rom_addr_v[2]),
    .rom_data(rom_data_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .result(result_v[2]), .illegal(illegal_v[2]), .dbg_addr(dbg_addr_v[2]),
    .dbg_data(dbg_data_v[2]));

  typedef struct {
    string            name;
    int               sel;
    int               n;
    logic [0:7][23:0] prog;
    int               exp_busy;
    logic [7:0]       exp_result;
    logic             exp_illegal;
    logic [0:3][3:0]  ra;
    logic [0:3][7:0]  rv;
  } vec_t;

  vec_t vecs [7];

  function automatic vec_t mkv(string nm, int sel, int n, logic [0:7][23:0] p,
                               int bsy, logic [7:0] res, logic ill,
                               logic [0:3][3:0] ra, logic [0:3][7:0] rv);
    vec_t v;
    v.name = nm; v.sel = sel; v.n = n; v.prog = p; v.exp_busy = bsy;
    v.exp_result = res; v.exp_illegal = ill; v.ra = ra; v.rv = rv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 3; s++) begin
      for (int r = 0; r < 16; r++) m_regs[s][r] = 8'h00;
      m_result[s]  = 8'h00;
      m_illegal[s] = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    start_v = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic clear_rom(input int sel);
    for (int a = 0; a < 256; a++) rom_mem[sel][a] = 24'h000000;
  endtask

  // Instruction-level interpreter: one loop iteration per instruction.
  task automatic model_run(input int sel, output int steps);
    int         pc, op, wa, ra1, ra2, val;
    logic [23:0] w;
    logic [7:0]  imm;
    bit          fin, jumped;
    pc = 0; steps = 0; fin = 0;
    while (!fin && steps < 2000) begin
      w   = rom_mem[sel][pc];
      op  = int'(w[23:20]);
      wa  = int'(w[19:16]);
      ra1 = int'(w[15:12]);
      ra2 = int'(w[11:8]);
      imm = w[7:0];
      steps++;
      jumped = 0;
      val = -1;
      case (op)
        0: ;
        1: val = (int'(m_regs[sel][ra1]) + int'(m_regs[sel][ra2])) % 256;
        2: val = (int'(m_regs[sel][ra1]) - int'(m_regs[sel][ra2]) + 256) % 256;
        3: val = int'(m_regs[sel][ra1] & m_regs[sel][ra2]);
        4: val = int'(m_regs[sel][ra1] | m_regs[sel][ra2]);
        5: val = (int'(m_regs[sel][ra1]) + int'(imm)) % 256;
        6: val = int'(imm);
        7: if (m_regs[sel][ra1] == 8'h00) begin
             if (int'(imm) >= plen[sel]) begin
               m_illegal[sel] = 1'b1;
               fin = 1;
             end else begin
               pc = int'(imm);
               jumped = 1;
             end
           end
        15: fin = 1;
        default: m_illegal[sel] = 1'b1;
      endcase
      if (val >= 0) begin
        m_regs[sel][wa] = 8'(val);
        m_result[sel]   = 8'(val);
      end
      if (!fin && !jumped) begin
        if (pc == plen[sel] - 1) fin = 1;
        else pc++;
      end
    end
  endtask

  task automatic run_prog(input int sel, input string tag, output int bc);
    bit seen;
    bc = 0; seen = 0;
    @(negedge clk);
    start_v[sel] = 1'b1;
    @(negedge clk);
    start_v[sel] = 1'b0;
    for (int g = 0; g < 3000 && !seen; g++) begin
      if (done_v[sel]) seen = 1;
      else begin
        if (busy_v[sel]) bc++;
        @(negedge clk);
      end
    end
    chk({tag, " done_seen"}, 32'(seen), 32'd1);
    chk({tag, " busy_in_done"}, 32'(busy_v[sel]), 32'd0);
    @(negedge clk);
    chk({tag, " done_one_cycle"}, 32'(done_v[sel]), 32'd0);
  endtask

  task automatic chk_reg(input int sel, input int a, input logic [7:0] exp, input string tag);
    dbg_addr_v[sel] = 4'(a);
    #1;
    chk($sformatf("%s R%0d", tag, a), 32'(dbg_data_v[sel]), 32'(exp));
  endtask

  initial begin
    int bc, dc, steps, len;
    logic [3:0] op;
    logic [7:0] imm;
    n_checks = 0; n_errors = 0;
    reset = 1'b1; start_v = '0; dbg_addr_v = '0;
    plen[0] = 256; plen[1] = 2; plen[2] = 4;
    for (int s = 0; s < 3; s++) clear_rom(s);

    vecs[0] = mkv("basic", 0, 4,
      {24'h610005, 24'h6200FD, 24'h131200, 24'hF00000, 24'h0, 24'h0, 24'h0, 24'h0},
      8, 8'h02, 1'b0, {4'd1, 4'd2, 4'd3, 4'd0}, {8'h05, 8'hFD, 8'h02, 8'h00});
    vecs[1] = mkv("loop", 0, 5,
      {24'h610003, 24'h5110FF, 24'h701004, 24'h700001, 24'hF00000, 24'h0, 24'h0, 24'h0},
      20, 8'h00, 1'b0, {4'd1, 4'd0, 4'd2, 4'd3}, {8'h00, 8'h00, 8'h00, 8'h00});
    vecs[2] = mkv("wrap", 0, 6,
      {24'h61007F, 24'h521001, 24'h230100, 24'h341200, 24'h451200, 24'hF00000, 24'h0, 24'h0},
      12, 8'hFF, 1'b0, {4'd2, 4'd3, 4'd4, 4'd5}, {8'h80, 8'h81, 8'h00, 8'hFF});
    vecs[3] = mkv("illegal_end", 1, 2,
      {24'h800000, 24'h000000, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0},
      4, 8'h00, 1'b1, {4'd0, 4'd1, 4'd2, 4'd15}, {8'h00, 8'h00, 8'h00, 8'h00});
    vecs[4] = mkv("beqz_oob", 2, 1,
      {24'h700009, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0},
      2, 8'h00, 1'b1, {4'd0, 4'd1, 4'd9, 4'd15}, {8'h00, 8'h00, 8'h00, 8'h00});
    vecs[5] = mkv("end_no_halt", 2, 4,
      {24'h610001, 24'h620002, 24'h000000, 24'h000000, 24'h0, 24'h0, 24'h0, 24'h0},
      8, 8'h02, 1'b0, {4'd1, 4'd2, 4'd0, 4'd3}, {8'h01, 8'h02, 8'h00, 8'h00});
    vecs[6] = mkv("branch_to_last", 2, 4,
      {24'h700003, 24'h610009, 24'h000000, 24'h6200AA, 24'h0, 24'h0, 24'h0, 24'h0},
      4, 8'hAA, 1'b0, {4'd1, 4'd2, 4'd0, 4'd3}, {8'h00, 8'hAA, 8'h00, 8'h00});

    // Reset state, and reset winning over start
    do_reset();
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("rst busy%0d", s), 32'(busy_v[s]), 32'd0);
      chk($sformatf("rst done%0d", s), 32'(done_v[s]), 32'd0);
      chk($sformatf("rst result%0d", s), 32'(result_v[s]), 32'd0);
      chk($sformatf("rst illegal%0d", s), 32'(illegal_v[s]), 32'd0);
      chk($sformatf("rst rom_addr%0d", s), 32'(rom_addr_v[s]), 32'd0);
    end
    @(negedge clk);
    reset = 1'b1; start_v = 3'b111;
    @(negedge clk);
    chk("reset_and_start busy", 32'(busy_v), 32'd0);
    reset = 1'b0; start_v = '0;
    @(negedge clk);
    chk("after_reset_start busy", 32'(busy_v), 32'd0);

    // Directed vectors
    for (int v = 0; v < 7; v++) begin
      do_reset();
      clear_rom(vecs[v].sel);
      for (int i = 0; i < vecs[v].n; i++) rom_mem[vecs[v].sel][i] = vecs[v].prog[i];
      run_prog(vecs[v].sel, vecs[v].name, bc);
      chk({vecs[v].name, " busy_cycles"}, 32'(bc), 32'(vecs[v].exp_busy));
      chk({vecs[v].name, " result"}, 32'(result_v[vecs[v].sel]), 32'(vecs[v].exp_result));
      chk({vecs[v].name, " illegal"}, 32'(illegal_v[vecs[v].sel]), 32'(vecs[v].exp_illegal));
      for (int k = 0; k < 4; k++)
        chk_reg(vecs[v].sel, int'(vecs[v].ra[k]), vecs[v].rv[k], vecs[v].name);
    end

    // Handshake: extra starts while busy are ignored; rerun keeps state
    do_reset();
    clear_rom(2);
    rom_mem[2][0] = 24'h610005; rom_mem[2][1] = 24'h900000;
    rom_mem[2][2] = 24'h6200FD; rom_mem[2][3] = 24'hF00000;
    @(negedge clk);
    start_v[2] = 1'b1;
    @(negedge clk);
    start_v[2] = 1'b0;
    bc = 0; dc = 0;
    for (int c = 0; c < 30; c++) begin
      if (busy_v[2]) bc++;
      if (done_v[2]) dc++;
      start_v[2] = (c == 2 || c == 4 || c == 6);
      @(negedge clk);
    end
    start_v[2] = 1'b0;
    chk("handshake busy_cycles", 32'(bc), 32'd8);
    chk("handshake done_pulses", 32'(dc), 32'd1);
    chk("handshake illegal", 32'(illegal_v[2]), 32'd1);
    chk_reg(2, 1, 8'h05, "handshake");
    chk_reg(2, 2, 8'hFD, "handshake");
    run_prog(2, "rerun", bc);
    chk("rerun busy_cycles", 32'(bc), 32'd8);
    chk("rerun illegal_sticky", 32'(illegal_v[2]), 32'd1);
    chk("rerun result", 32'(result_v[2]), 32'hFD);
    chk_reg(2, 1, 8'h05, "rerun");
    chk_reg(2, 2, 8'hFD, "rerun");

    // Reset during EXEC of the second instruction of the basic program
    do_reset();
    clear_rom(0);
    for (int i = 0; i < 4; i++) rom_mem[0][i] = vecs[0].prog[i];
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk_reg(0, 1, 8'h05, "midrun_before");
    chk("midrun rom_addr_before", 32'(rom_addr_v[0]), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrun busy", 32'(busy_v[0]), 32'd0);
    chk("midrun rom_addr", 32'(rom_addr_v[0]), 32'd0);
    chk("midrun result", 32'(result_v[0]), 32'd0);
    chk_reg(0, 1, 8'h00, "midrun");
    reset = 1'b0;
    model_reset();
    dc = 0;
    for (int c = 0; c < 8; c++) begin
      if (done_v[0] || busy_v[0]) dc++;
      @(negedge clk);
    end
    chk("midrun no_done_no_busy", 32'(dc), 32'd0);
    run_prog(0, "after_midrun", bc);
    chk("after_midrun busy_cycles", 32'(bc), 32'd8);
    chk_reg(0, 3, 8'h02, "after_midrun");

    // Random forward-branching programs against the interpreter, back to back
    do_reset();
    for (int it = 0; it < 25; it++) begin
      clear_rom(0);
      len = int'($urandom_range(3, 16));
      for (int i = 0; i < len - 1; i++) begin
        op  = 4'($urandom_range(0, 15));
        imm = (op == 4'h7) ? 8'($urandom_range(i + 1, len - 1)) : 8'($urandom);
        rom_mem[0][i] = {op, 4'($urandom), 4'($urandom), 4'($urandom), imm};
      end
      rom_mem[0][len-1] = ($urandom_range(0, 3) != 0) ? 24'hF00000 : 24'h000000;
      model_run(0, steps);
      run_prog(0, $sformatf("rand%0d", it), bc);
      chk($sformatf("rand%0d busy_cycles", it), 32'(bc), 32'(2 * steps));
      chk($sformatf("rand%0d result", it), 32'(result_v[0]), 32'(m_result[0]));
      chk($sformatf("rand%0d illegal", it), 32'(illegal_v[0]), 32'(m_illegal[0]));
      for (int r = 0; r < 16; r++)
        chk_reg(0, r, m_regs[0][r], $sformatf("rand%0d", it));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
